uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of byte requesters (range 2..8).
REQ-002 Parameter GAP_CYCLES, 16, idle clock cycles forced after each completed byte (one bit time at 16x clock).
REQ-003 Parameter TIMEOUT_CYCLES, 4096, maximum clock cycles to wait for tx_ready before abandoning a byte.
REQ-004 clock  in  1  UART 16x-baud clock; the only clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  NUM_REQ  bit i high = requester i has a byte pending.
REQ-007 req_data  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
REQ-008 req_accept  out  NUM_REQ  one-cycle pulse on bit i when requester i's byte is latched.
REQ-009 tx_bits  out  8  byte driven to UART io_dataIn_bits.
REQ-010 tx_ready  in  1  UART io_dataIn_ready; one-cycle pulse at byte completion.
REQ-011 busy  out  1  high in SEND or GAP.
REQ-012 grant_idx  out  3  index of the requester whose byte is in flight; holds the last value otherwise.
REQ-013 timeout_err  out  1  sticky flag; set on any timeout, cleared only by reset.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SEND, GAP.
REQ-015 In IDLE with req_valid == 0, the block SHALL stay in IDLE and drive tx_bits = 8'h00 (no-op byte).
REQ-016 In IDLE with any req_valid bit set, the block SHALL select the requester by round-robin, starting at (last_grant+1) mod NUM_REQ.
REQ-017 On the selection edge, the block SHALL latch the selected byte into tx_bits, update grant_idx and last_grant, pulse the selected req_accept bit for one cycle, clear the wait counter, and enter SEND.
REQ-018 Latency: req_valid sampled high in IDLE at edge N SHALL give tx_bits and req_accept valid after edge N.
REQ-019 At most one req_accept bit SHALL be high in any cycle.
REQ-020 In SEND, tx_bits SHALL hold stable; requester inputs SHALL be ignored.
REQ-021 In SEND, tx_ready == 1 SHALL load the gap counter with GAP_CYCLES-1 and move to GAP.
REQ-022 In SEND, the wait counter SHALL increment each cycle; when it reaches TIMEOUT_CYCLES-1 without tx_ready, the block SHALL set timeout_err and move to GAP.
REQ-023 If tx_ready and the timeout coincide, tx_ready SHALL win and timeout_err SHALL NOT be set.
REQ-024 In GAP, tx_bits SHALL be 8'h00; the counter SHALL decrement, and at 0 the block SHALL return to IDLE.
REQ-025 tx_ready in IDLE or GAP SHALL be ignored.
REQ-026 A requester dropping req_valid after acceptance SHALL NOT affect the byte in flight; a requester holding req_valid SHALL be re-served only after the others pending in round-robin order.
REQ-027 Counter widths SHALL be $clog2 of the respective parameter; wrap-around SHALL NOT occur.

Reset
REQ-028 While reset is high at a clock edge, the block SHALL enter IDLE with tx_bits = 0, req_accept = 0, busy = 0, grant_idx = 0, timeout_err = 0, counters = 0, and last_grant = NUM_REQ-1, so requester 0 has first priority.
REQ-029 Reset asserted mid-SEND or mid-GAP SHALL abandon the byte; no req_accept SHALL be reissued for it.

Structure
REQ-030 State encodings, GAP_CYCLES/TIMEOUT_CYCLES defaults, and the no-op byte value 8'h00 SHALL live in a shared package (uart_pkg).
REQ-031 Round-robin selection SHALL be a combinational sub-module, rr_picker (inputs: request vector, last_grant; outputs: found, index).

Verification
REQ-032 Single request: req_valid = 4'b0100, data[2] = 8'h5A -> next cycle req_accept = 4'b0100, tx_bits = 8'h5A, grant_idx = 2; after tx_ready, busy stays high exactly 16 cycles.
REQ-033 Fairness: all four valid and held for 8 completions -> grant order 0,1,2,3,0,1,2,3.
REQ-034 Timeout: byte 8'h33 granted, tx_ready never pulses -> after 4096 SEND cycles timeout_err = 1, GAP entered, next grant proceeds normally.
REQ-035 Coincidence: tx_ready pulses on the cycle the wait counter hits 4095 -> timeout_err stays 0.
REQ-036 Reset mid-SEND: reset high for 1 cycle during SEND of 8'hA1 -> tx_bits = 0, busy = 0, grant_idx = 0; with all requesters valid, the first grant after reset goes to requester 0.
REQ-037 Stray tx_ready pulses in IDLE and GAP -> no state change and no req_accept pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM encoding, default timing, the no-op byte and the round-robin wrap helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    localparam int         GAP_CYCLES_DEF     = 16;
    localparam int         TIMEOUT_CYCLES_DEF = 4096;
    localparam logic [7:0] NOOP_BYTE          = 8'h00;
    localparam int         IDX_W              = 3;

    // Callers never pass a position above 2n-1, so one conditional subtract is a full modulo.
    function automatic logic [IDX_W-1:0] rr_wrap(input int pos, input int n);
        int r;
        if (pos >= n) begin
            r = pos - n;
        end else begin
            r = pos;
        end
        return IDX_W'(r);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Returns the first requester found after last_grant, wrapping around.
module rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    logic hit_s;

    // Walk offsets from farthest to nearest so the closest pending requester overrides.
    always_comb begin
        found = 1'b0;
        index = {IDX_W{1'b0}};
        hit_s = 1'b0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                hit_s = req[i] && (rr_wrap(int'(last_grant) + off, NUM_REQ) == IDX_W'(i));
                found = found | hit_s;
                index = hit_s ? IDX_W'(i) : index;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte requesters onto a single UART transmitter.
// Each byte is followed by a forced idle gap; a byte that never completes is abandoned on timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_accept,
    output logic [7:0]           tx_bits,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [2:0]           grant_idx,
    output logic                 timeout_err
);

    localparam int                GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int                WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e          state_r;
    logic [IDX_W-1:0]    last_grant_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [GAP_W-1:0]    gap_cnt_r;
    logic [7:0]          tx_bits_r;
    logic [NUM_REQ-1:0]  req_accept_r;
    logic                busy_r;
    logic [IDX_W-1:0]    grant_idx_r;
    logic                timeout_err_r;

    logic                pick_found_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic [7:0]          pick_byte_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .found      (pick_found_s),
        .index      (pick_idx_s)
    );

    // Select the byte lane of the picked requester.
    always_comb begin
        pick_byte_s = NOOP_BYTE;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_byte_s = (pick_idx_s == IDX_W'(i)) ? req_data[i*8 +: 8] : pick_byte_s;
        end
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= IDX_W'(NUM_REQ - 1);
            wait_cnt_r    <= {WAIT_W{1'b0}};
            gap_cnt_r     <= {GAP_W{1'b0}};
            tx_bits_r     <= NOOP_BYTE;
            req_accept_r  <= {NUM_REQ{1'b0}};
            busy_r        <= 1'b0;
            grant_idx_r   <= {IDX_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        tx_bits_r    <= pick_byte_s;
                        grant_idx_r  <= pick_idx_s;
                        last_grant_r <= pick_idx_s;
                        req_accept_r <= NUM_REQ'(1) << pick_idx_s;
                        wait_cnt_r   <= {WAIT_W{1'b0}};
                        busy_r       <= 1'b1;
                        state_r      <= ST_SEND;
                    end else begin
                        tx_bits_r    <= NOOP_BYTE;
                        req_accept_r <= {NUM_REQ{1'b0}};
                    end
                end
                ST_SEND: begin
                    req_accept_r <= {NUM_REQ{1'b0}};
                    // Completion is checked first so a coincident tx_ready beats the timeout.
                    if (tx_ready) begin
                        gap_cnt_r <= GAP_LOAD;
                        tx_bits_r <= NOOP_BYTE;
                        state_r   <= ST_GAP;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        timeout_err_r <= 1'b1;
                        gap_cnt_r     <= GAP_LOAD;
                        tx_bits_r     <= NOOP_BYTE;
                        state_r       <= ST_GAP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_GAP: begin
                    req_accept_r <= {NUM_REQ{1'b0}};
                    tx_bits_r    <= NOOP_BYTE;
                    if (gap_cnt_r == {GAP_W{1'b0}}) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GAP_W'(1);
                    end
                end
                default: begin
                    req_accept_r <= {NUM_REQ{1'b0}};
                    tx_bits_r    <= NOOP_BYTE;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_accept  = req_accept_r;
    assign tx_bits     = tx_bits_r;
    assign busy        = busy_r;
    assign grant_idx   = grant_idx_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences,
// and randomized traffic against a behavioural model.
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int GAP     = 16;
    localparam int TIMEOUT = 4096;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_accept;
    logic [7:0]     tx_bits;
    logic           tx_ready;
    logic           busy;
    logic [2:0]     grant_idx;
    logic           timeout_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] valid;
        logic [7:0] data;
        logic [2:0] exp_idx;
    } vec_t;

    vec_t vecs[6];

    // Behavioural model state: phase 0 idle, 1 sending, 2 gap.
    int         m_phase, m_elapsed, m_gap_left, m_last, m_grant;
    logic [7:0] m_tx;
    logic [3:0] m_acc;
    logic       m_busy, m_err;

    always #5 clock = ~clock;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_accept  (req_accept),
        .tx_bits     (tx_bits),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .grant_idx   (grant_idx),
        .timeout_err (timeout_err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0000_0000;
        tx_ready  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_accept(input string name);
        int n;
        n = 0;
        while (req_accept == 4'b0000 && n < 60) begin
            tick();
            n++;
        end
        chk(name, 32'(req_accept != 4'b0000), 32'd1);
    endtask

    task automatic m_step(input logic [3:0] v, input logic [31:0] d, input logic tr, input logic rs);
        int pick;
        if (rs) begin
            m_phase = 0; m_tx = 8'h00; m_acc = 4'b0000; m_busy = 1'b0; m_grant = 0;
            m_err = 1'b0; m_last = N - 1; m_elapsed = 0; m_gap_left = 0;
        end else begin
            m_acc = 4'b0000;
            if (m_phase == 0) begin
                pick = -1;
                for (int off = 1; off <= N; off++) begin
                    if (pick < 0 && v[(m_last + off) % N]) pick = (m_last + off) % N;
                end
                if (pick >= 0) begin
                    m_tx = d[pick*8 +: 8]; m_acc = 4'b0001 << pick; m_grant = pick;
                    m_last = pick; m_elapsed = 0; m_phase = 1; m_busy = 1'b1;
                end else begin
                    m_tx = 8'h00;
                end
            end else if (m_phase == 1) begin
                m_elapsed++;
                if (tr || m_elapsed == TIMEOUT) begin
                    if (!tr) m_err = 1'b1;
                    m_phase = 2; m_gap_left = GAP; m_tx = 8'h00;
                end
            end else begin
                m_gap_left--;
                m_tx = 8'h00;
                if (m_gap_left == 0) begin
                    m_phase = 0; m_busy = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_acc;
        logic [3:0] acc_seen;
        int n;

        vecs[0] = '{4'b0100, 8'h5A, 3'd2};
        vecs[1] = '{4'b0001, 8'h11, 3'd0};
        vecs[2] = '{4'b1000, 8'hC3, 3'd3};
        vecs[3] = '{4'b0110, 8'h96, 3'd1};
        vecs[4] = '{4'b1111, 8'h3C, 3'd0};
        vecs[5] = '{4'b1010, 8'hD2, 3'd1};

        do_reset();
        chk("rst_tx", 32'(tx_bits), 32'd0);
        chk("rst_accept", 32'(req_accept), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_idx), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);

        // Single-request table, each from a fresh reset.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            exp_acc = 4'b0001 << vecs[v].exp_idx;
            for (int i = 0; i < N; i++) begin
                req_data[i*8 +: 8] = (3'(i) == vecs[v].exp_idx) ? vecs[v].data : (8'hE0 | 8'(i));
            end
            req_valid = vecs[v].valid;
            tick();
            chk("vec_accept", 32'(req_accept), 32'(exp_acc));
            chk("vec_tx", 32'(tx_bits), 32'(vecs[v].data));
            chk("vec_grant", 32'(grant_idx), 32'(vecs[v].exp_idx));
            chk("vec_busy", 32'(busy), 32'd1);
            req_valid = 4'b0000;
            tick();
            chk("vec_accept_pulse", 32'(req_accept), 32'd0);
            chk("vec_tx_hold", 32'(tx_bits), 32'(vecs[v].data));
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
            chk("vec_gap_tx", 32'(tx_bits), 32'd0);
            n = 0;
            while (busy && n < 100) begin
                n++;
                tick();
            end
            chk("vec_gap_len", 32'(n), 32'(GAP));
        end

        // Fairness: all requesters held valid for eight completions.
        do_reset();
        req_data  = 32'h1312_1110;
        req_valid = 4'b1111;
        tick();
        for (int k = 0; k < 8; k++) begin
            wait_accept("fair_wait");
            chk("fair_grant", 32'(grant_idx), 32'(k % 4));
            chk("fair_tx", 32'(tx_bits), 32'(8'h10 + 8'(k % 4)));
            tick();
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
            tick();
        end
        req_valid = 4'b0000;
        wait_idle("fair_idle");

        // Timeout: tx_ready never arrives.
        do_reset();
        req_data  = 32'h0000_0033;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        chk("to_tx", 32'(tx_bits), 32'h33);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("to_err_before", 32'(timeout_err), 32'd0);
        chk("to_tx_before", 32'(tx_bits), 32'h33);
        tick();
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_gap_busy", 32'(busy), 32'd1);
        chk("to_gap_tx", 32'(tx_bits), 32'd0);
        wait_idle("to_idle");
        req_data  = 32'h0000_7700;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        chk("to_next_accept", 32'(req_accept), 32'b0010);
        chk("to_next_tx", 32'(tx_bits), 32'h77);
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
        tick();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        wait_idle("to_next_idle");

        // Coincidence: tx_ready on the last wait cycle.
        do_reset();
        req_data  = 32'h0000_0044;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk("co_err", 32'(timeout_err), 32'd0);
        chk("co_busy", 32'(busy), 32'd1);
        chk("co_tx", 32'(tx_bits), 32'd0);
        wait_idle("co_idle");

        // Reset during SEND abandons the byte.
        do_reset();
        req_data  = 32'h00A1_0055;
        req_valid = 4'b0100;
        tick();
        chk("rs_tx", 32'(tx_bits), 32'hA1);
        chk("rs_grant", 32'(grant_idx), 32'd2);
        req_valid = 4'b1111;
        tick();
        tick();
        chk("rs_send_ignore", 32'(req_accept), 32'd0);
        chk("rs_send_hold", 32'(tx_bits), 32'hA1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_tx0", 32'(tx_bits), 32'd0);
        chk("rs_busy0", 32'(busy), 32'd0);
        chk("rs_grant0", 32'(grant_idx), 32'd0);
        chk("rs_accept0", 32'(req_accept), 32'd0);
        tick();
        chk("rs_first_accept", 32'(req_accept), 32'b0001);
        chk("rs_first_tx", 32'(tx_bits), 32'h55);
        req_valid = 4'b0000;
        tx_ready  = 1'b1;
        tick();
        tx_ready = 1'b0;
        wait_idle("rs_idle");

        // Stray tx_ready in IDLE and GAP.
        do_reset();
        tx_ready = 1'b1;
        acc_seen = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            acc_seen = acc_seen | req_accept;
        end
        chk("st_idle_busy", 32'(busy), 32'd0);
        chk("st_idle_accept", 32'(acc_seen), 32'd0);
        tx_ready  = 1'b0;
        req_data  = 32'h0000_0099;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        tx_ready = 1'b1;
        tick();
        acc_seen = 4'b0000;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
            acc_seen = acc_seen | req_accept;
        end
        tx_ready = 1'b0;
        chk("st_gap_len", 32'(n), 32'(GAP));
        chk("st_gap_accept", 32'(acc_seen), 32'd0);
        chk("st_gap_err", 32'(timeout_err), 32'd0);

        // Randomized traffic against the model.
        reset     = 1'b1;
        req_valid = 4'b0000;
        tx_ready  = 1'b0;
        m_step(req_valid, req_data, tx_ready, reset);
        tick();
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 299) == 0);
            req_valid = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            req_data  = $urandom;
            tx_ready  = ($urandom_range(0, 3) == 0);
            m_step(req_valid, req_data, tx_ready, reset);
            tick();
            chk("rnd_tx", 32'(tx_bits), 32'(m_tx));
            chk("rnd_accept", 32'(req_accept), 32'(m_acc));
            chk("rnd_busy", 32'(busy), 32'(m_busy));
            chk("rnd_grant", 32'(grant_idx), 32'(m_grant));
            chk("rnd_err", 32'(timeout_err), 32'(m_err));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
